// File: rtl/avalon_pkg.sv
// Shared definitions for the classifier Avalon-MM slave: address map, handshake states, response codes.
package avalon_pkg;

  localparam logic [10:0] CTRL_ADDR    = 11'h000;
  localparam logic [10:0] SCRATCH_ADDR = 11'h001;
  localparam logic [10:0] RESULT_BASE  = 11'h002;
  localparam logic [10:0] PIXEL_BASE   = 11'h010;
  localparam logic [10:0] WEIGHT_BASE  = 11'h400;

  localparam int DEF_NUM_PIXELS  = 784;
  localparam int DEF_NUM_CLASSES = 10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACCEPT,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_CTRL,
    RGN_SCRATCH,
    RGN_RESULT,
    RGN_PIXEL,
    RGN_WEIGHT
  } region_t;

  // First address past a region of the given depth.
  function automatic logic [10:0] region_limit(input logic [10:0] base, input int depth);
    return base + 11'(depth);
  endfunction

endpackage

// File: rtl/avalon_addr_decode.sv
// Combinational address decoder: word address -> region, region-relative index, decode error.
module avalon_addr_decode
  import avalon_pkg::*;
#(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
  input  logic [10:0] addr_i,
  output region_t     region_o,
  output logic [9:0]  index_o,
  output logic        dec_err_o
);

  localparam logic [10:0] RESULT_LIMIT = region_limit(RESULT_BASE, NUM_CLASSES);
  localparam logic [10:0] PIXEL_LIMIT  = region_limit(PIXEL_BASE, NUM_PIXELS);
  localparam logic [10:0] WEIGHT_LIMIT = region_limit(WEIGHT_BASE, NUM_PIXELS);

  always_comb begin
    region_o = RGN_NONE;
    index_o  = '0;
    if (addr_i == CTRL_ADDR) begin
      region_o = RGN_CTRL;
    end else if (addr_i == SCRATCH_ADDR) begin
      region_o = RGN_SCRATCH;
    end else if (addr_i >= RESULT_BASE && addr_i < RESULT_LIMIT) begin
      region_o = RGN_RESULT;
      index_o  = 10'(addr_i - RESULT_BASE);
    end else if (addr_i >= PIXEL_BASE && addr_i < PIXEL_LIMIT) begin
      region_o = RGN_PIXEL;
      index_o  = 10'(addr_i - PIXEL_BASE);
    end else if (addr_i >= WEIGHT_BASE && addr_i < WEIGHT_LIMIT) begin
      region_o = RGN_WEIGHT;
      index_o  = 10'(addr_i - WEIGHT_BASE);
    end
  end

  assign dec_err_o = (region_o == RGN_NONE);

endmodule

// File: rtl/avalon_interface.sv
// Avalon-MM slave front end for the classifier: capture, one busy cycle, one accept cycle
// (waitrequest low, write data sampled), then a one-cycle response; bursts repeat busy/accept per beat.
module avalon_interface
  import avalon_pkg::*;
#(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        write,
  input  logic        read,
  input  logic        beginbursttransfer,
  input  logic [9:0]  burstcount,
  input  logic [10:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] result_output,
  input  logic        done_calc,
  output logic [9:0]  weight_address,
  output logic        w_enable_weights,
  output logic [9:0]  pixel_address,
  output logic        w_enable_pixels,
  output logic [15:0] store_data,
  output logic [3:0]  output_address,
  output logic        readdatavalid,
  output logic        writeresponsevalid,
  output logic        waitrequest,
  output logic        start_calc,
  output logic [1:0]  response
);

  state_t      state_q, state_d;
  region_t     rgn_q, rgn_d;
  region_t     dec_rgn;
  logic [9:0]  dec_idx;
  logic        dec_err;

  logic [10:0] idx_q, idx_d;
  logic [9:0]  beats_q, beats_d;
  logic        wr_cmd_q, wr_cmd_d;
  logic        err_q, err_d;
  logic [31:0] scratch_q, scratch_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        rdv_q, rdv_d;
  logic        wrv_q, wrv_d;
  logic        start_q, start_d;
  logic        wen_px_q, wen_px_d;
  logic        wen_wt_q, wen_wt_d;
  logic [9:0]  px_addr_q, px_addr_d;
  logic [9:0]  wt_addr_q, wt_addr_d;
  logic [15:0] store_q, store_d;
  logic [3:0]  oaddr_q, oaddr_d;
  logic        beat_err;
  logic        in_range;

  avalon_addr_decode #(
    .NUM_PIXELS (NUM_PIXELS),
    .NUM_CLASSES(NUM_CLASSES)
  ) u_decode (
    .addr_i   (address),
    .region_o (dec_rgn),
    .index_o  (dec_idx),
    .dec_err_o(dec_err)
  );

  always_comb begin
    state_d   = state_q;
    rgn_d     = rgn_q;
    idx_d     = idx_q;
    beats_d   = beats_q;
    wr_cmd_d  = wr_cmd_q;
    err_d     = err_q;
    scratch_d = scratch_q;
    done_d    = done_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    px_addr_d = px_addr_q;
    wt_addr_d = wt_addr_q;
    store_d   = store_q;
    oaddr_d   = oaddr_q;
    rdv_d     = 1'b0;
    wrv_d     = 1'b0;
    start_d   = 1'b0;
    wen_px_d  = 1'b0;
    wen_wt_d  = 1'b0;
    beat_err  = 1'b0;
    in_range  = (idx_q < 11'(NUM_PIXELS));

    if (done_calc) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (read || write) begin
          state_d  = BUSY;
          wr_cmd_d = write;
          rgn_d    = dec_rgn;
          idx_d    = {1'b0, dec_idx};
          err_d    = dec_err;
          // Bursts are honoured only for writes; a burst read runs as one beat.
          if (write && beginbursttransfer) begin
            beats_d = (burstcount == 10'd0) ? 10'd1 : burstcount;
          end else begin
            beats_d = 10'd1;
          end
          if (dec_rgn == RGN_RESULT) begin
            oaddr_d = dec_idx[3:0];
          end
        end
      end

      BUSY: state_d = ACCEPT;

      ACCEPT: begin
        if (wr_cmd_q) begin
          case (rgn_q)
            RGN_CTRL: begin
              // A start issued in the same cycle as done_calc overrides it.
              if (writedata[0]) begin
                start_d = 1'b1;
                done_d  = 1'b0;
                busy_d  = 1'b1;
              end
            end
            RGN_SCRATCH: scratch_d = writedata;
            RGN_PIXEL: begin
              if (in_range) begin
                wen_px_d  = 1'b1;
                px_addr_d = idx_q[9:0];
                store_d   = writedata[15:0];
              end else begin
                beat_err = 1'b1;
              end
            end
            RGN_WEIGHT: begin
              if (in_range) begin
                wen_wt_d  = 1'b1;
                wt_addr_d = idx_q[9:0];
                store_d   = writedata[15:0];
              end else begin
                beat_err = 1'b1;
              end
            end
            default: beat_err = 1'b1;
          endcase

          err_d = err_q | beat_err;
          if (beats_q > 10'd1) begin
            beats_d = beats_q - 10'd1;
            idx_d   = idx_q + 11'd1;
            state_d = BUSY;
          end else begin
            state_d = RESP;
            wrv_d   = 1'b1;
            resp_d  = (err_q | beat_err) ? RESP_DECERR : RESP_OKAY;
          end
        end else begin
          state_d = RESP;
          rdv_d   = 1'b1;
          rdata_d = '0;
          resp_d  = RESP_OKAY;
          case (rgn_q)
            RGN_CTRL:    rdata_d = {30'b0, busy_q, done_q};
            RGN_SCRATCH: rdata_d = scratch_q;
            RGN_RESULT:  rdata_d = result_output;
            default:     resp_d  = RESP_DECERR;
          endcase
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= IDLE;
      rgn_q     <= RGN_NONE;
      idx_q     <= '0;
      beats_q   <= '0;
      wr_cmd_q  <= 1'b0;
      err_q     <= 1'b0;
      scratch_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      rdv_q     <= 1'b0;
      wrv_q     <= 1'b0;
      start_q   <= 1'b0;
      wen_px_q  <= 1'b0;
      wen_wt_q  <= 1'b0;
      px_addr_q <= '0;
      wt_addr_q <= '0;
      store_q   <= '0;
      oaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      rgn_q     <= rgn_d;
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      wr_cmd_q  <= wr_cmd_d;
      err_q     <= err_d;
      scratch_q <= scratch_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      rdv_q     <= rdv_d;
      wrv_q     <= wrv_d;
      start_q   <= start_d;
      wen_px_q  <= wen_px_d;
      wen_wt_q  <= wen_wt_d;
      px_addr_q <= px_addr_d;
      wt_addr_q <= wt_addr_d;
      store_q   <= store_d;
      oaddr_q   <= oaddr_d;
    end
  end

  assign waitrequest        = (state_q != ACCEPT);
  assign readdata           = rdata_q;
  assign response           = resp_q;
  assign readdatavalid      = rdv_q;
  assign writeresponsevalid = wrv_q;
  assign start_calc         = start_q;
  assign w_enable_pixels    = wen_px_q;
  assign w_enable_weights   = wen_wt_q;
  assign pixel_address      = px_addr_q;
  assign weight_address     = wt_addr_q;
  assign store_data         = store_q;
  assign output_address     = oaddr_q;

endmodule

// File: tb/tb_avalon_interface.sv
// Randomized bench for avalon_interface: bus tasks drive the Avalon handshake, a negedge monitor
// collects strobes, and a small map-level model supplies every expected value.
module tb_avalon_interface;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        write, read, beginbursttransfer, done_calc;
  logic [9:0]  burstcount;
  logic [10:0] address;
  logic [31:0] writedata, result_output;
  logic [31:0] readdata;
  logic [9:0]  weight_address, pixel_address;
  logic        w_enable_weights, w_enable_pixels;
  logic [15:0] store_data;
  logic [3:0]  output_address;
  logic        readdatavalid, writeresponsevalid, waitrequest, start_calc;
  logic [1:0]  response;

  always #5 clk = ~clk;

  avalon_interface dut (
    .clk(clk), .n_rst(n_rst), .write(write), .read(read),
    .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
    .address(address), .writedata(writedata), .readdata(readdata),
    .result_output(result_output), .done_calc(done_calc),
    .weight_address(weight_address), .w_enable_weights(w_enable_weights),
    .pixel_address(pixel_address), .w_enable_pixels(w_enable_pixels),
    .store_data(store_data), .output_address(output_address),
    .readdatavalid(readdatavalid), .writeresponsevalid(writeresponsevalid),
    .waitrequest(waitrequest), .start_calc(start_calc), .response(response)
  );

  int checks = 0;
  int passed = 0;

  // Strobe monitor
  int          rdv_n = 0, wrv_n = 0, start_n = 0;
  logic [31:0] last_rd = '0;
  logic [1:0]  last_rsp = '0;
  logic [25:0] px_ev[$];
  logic [25:0] wt_ev[$];

  always @(negedge clk) begin
    if (readdatavalid) begin rdv_n++; last_rd = readdata; last_rsp = response; end
    if (writeresponsevalid) begin wrv_n++; last_rsp = response; end
    if (start_calc) start_n++;
    if (w_enable_pixels) px_ev.push_back({pixel_address, store_data});
    if (w_enable_weights) wt_ev.push_back({weight_address, store_data});
  end

  // Reference model of the register map
  logic [31:0] m_scratch;
  logic        m_busy, m_done;

  task automatic wait_accept(input string what);
    int t = 0;
    do begin @(negedge clk); t++; end while (waitrequest !== 1'b0 && t < 20);
    if (waitrequest !== 1'b0) begin
      checks++;
      $display("FAIL %s timeout: waitrequest=%b, want 0 within 20 cycles", what, waitrequest);
    end
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [31:0] d, input bit pulse_done);
    address = a; writedata = d; write = 1'b1; beginbursttransfer = 1'b0; burstcount = 10'd1;
    wait_accept("write");
    if (pulse_done) done_calc = 1'b1;
    @(negedge clk);
    write = 1'b0; done_calc = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_read(input logic [10:0] a, input bit early_drop);
    address = a; read = 1'b1;
    if (early_drop) begin @(negedge clk); read = 1'b0; end
    wait_accept("read");
    @(negedge clk);
    read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_burst(input logic [10:0] a, input int n, input logic [31:0] d0);
    address = a; write = 1'b1; beginbursttransfer = 1'b1; burstcount = 10'(n); writedata = d0;
    for (int k = 0; k < n; k++) begin
      wait_accept("burst beat");
      @(negedge clk);
      beginbursttransfer = 1'b0;
      writedata = d0 + 32'(k + 1);
    end
    write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [78:0] outs;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    outs = {readdata, weight_address, w_enable_weights, pixel_address, w_enable_pixels, store_data,
            output_address, readdatavalid, writeresponsevalid, start_calc, response};
    checks++; if (waitrequest !== 1'b1) $display("FAIL reset_waitrequest: got %b want 1", waitrequest); else passed++;
    checks++; if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else passed++;
    checks++; if (response !== 2'b00) $display("FAIL reset_response: got %b want 00", response); else passed++;
    n_rst = 1'b0;
    m_scratch = '0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic test_scratch();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      int snap_w, snap_r;
      d = (i == 0) ? 32'hF0F0F0F0 : $urandom();
      snap_w = wrv_n;
      bus_write(11'h001, d, 1'b0);
      m_scratch = d;
      checks++; if (wrv_n - snap_w !== 1) $display("FAIL scratch_wrv: got %0d pulses want 1", wrv_n - snap_w); else passed++;
      snap_r = rdv_n;
      bus_read(11'h001, 1'b0);
      checks++; if (last_rd !== m_scratch) $display("FAIL scratch_data: got %h want %h", last_rd, m_scratch); else passed++;
      checks++; if (last_rsp !== 2'b00) $display("FAIL scratch_resp: got %b want 00", last_rsp); else passed++;
      checks++; if (rdv_n - snap_r !== 1) $display("FAIL scratch_rdv: got %0d pulses want 1", rdv_n - snap_r); else passed++;
    end
  endtask

  task automatic test_pixel();
    for (int i = 0; i < 6; i++) begin
      logic [10:0] a;
      logic [31:0] d;
      logic [25:0] exp_ev;
      logic [25:0] got;
      case (i)
        0: begin a = 11'h012; d = 32'h0001ABCD; end
        1: begin a = 11'h010; d = $urandom(); end
        2: begin a = 11'h31F; d = $urandom(); end
        default: begin a = 11'($urandom_range(16, 799)); d = $urandom(); end
      endcase
      exp_ev = {10'(a - 11'd16), d[15:0]};
      bus_write(a, d, 1'b0);
      checks++;
      if (px_ev.size() !== 1) $display("FAIL pixel_pulses addr %h: got %0d want 1", a, px_ev.size());
      else begin
        got = px_ev.pop_front();
        if (got !== exp_ev) $display("FAIL pixel_event addr %h: got idx/data %h want %h", a, got, exp_ev);
        else passed++;
      end
      checks++; if (wt_ev.size() !== 0) $display("FAIL pixel_no_weight: got %0d weight pulses want 0", wt_ev.size()); else passed++;
      checks++; if (last_rsp !== 2'b00) $display("FAIL pixel_resp: got %b want 00", last_rsp); else passed++;
      px_ev.delete(); wt_ev.delete();
    end
  endtask

  task automatic test_ctrl_result();
    int snap;
    snap = start_n;
    bus_write(11'h000, 32'h1, 1'b0);
    m_busy = 1'b1; m_done = 1'b0;
    checks++; if (start_n - snap !== 1) $display("FAIL start_pulse: got %0d want 1", start_n - snap); else passed++;
    bus_read(11'h000, 1'b0);
    checks++; if (last_rd !== {30'b0, m_busy, m_done}) $display("FAIL ctrl_busy: got %h want %h", last_rd, {30'b0, m_busy, m_done}); else passed++;
    done_calc = 1'b1; @(negedge clk); done_calc = 1'b0; @(negedge clk);
    m_busy = 1'b0; m_done = 1'b1;
    bus_read(11'h000, 1'b0);
    checks++; if (last_rd !== {30'b0, m_busy, m_done}) $display("FAIL ctrl_done: got %h want %h", last_rd, {30'b0, m_busy, m_done}); else passed++;
    // Start arriving together with done_calc: the start takes precedence.
    snap = start_n;
    bus_write(11'h000, 32'h1, 1'b1);
    m_busy = 1'b1; m_done = 1'b0;
    bus_read(11'h000, 1'b0);
    checks++; if (last_rd !== {30'b0, m_busy, m_done}) $display("FAIL start_wins: got %h want %h", last_rd, {30'b0, m_busy, m_done}); else passed++;
    checks++; if (start_n - snap !== 1) $display("FAIL start_wins_pulse: got %0d want 1", start_n - snap); else passed++;

    for (int i = 0; i < 4; i++) begin
      int idx;
      logic [31:0] v;
      idx = (i == 0) ? 3 : $urandom_range(0, 9);
      v = (i == 0) ? 32'h77 : $urandom();
      result_output = v;
      bus_read(11'(2 + idx), i[0]);
      checks++; if (last_rd !== v) $display("FAIL result_data idx %0d: got %h want %h", idx, last_rd, v); else passed++;
      checks++; if (output_address !== 4'(idx)) $display("FAIL result_oaddr: got %0d want %0d", output_address, idx); else passed++;
      checks++; if (last_rsp !== 2'b00) $display("FAIL result_resp: got %b want 00", last_rsp); else passed++;
    end
    bus_write(11'h004, $urandom(), 1'b0);
    checks++; if (last_rsp !== 2'b11) $display("FAIL result_write_resp: got %b want 11", last_rsp); else passed++;
  endtask

  task automatic test_burst();
    for (int s = 0; s < 3; s++) begin
      int base, n, snap;
      logic [31:0] d0;
      logic exp_err;
      logic [25:0] got, exp_ev;
      base = (s == 0) ? 0 : (s == 1) ? $urandom_range(0, 700) : 781;
      n    = (s == 0) ? 4 : (s == 1) ? $urandom_range(2, 8) : 5;
      d0   = (s == 0) ? 32'd1 : $urandom();
      snap = wrv_n;
      bus_burst(11'(1024 + base), n, d0);
      exp_err = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (base + k < 784) begin
          exp_ev = {10'(base + k), 16'(d0 + 32'(k))};
          checks++;
          if (wt_ev.size() == 0) $display("FAIL burst_missing beat %0d: got none want %h", k, exp_ev);
          else begin
            got = wt_ev.pop_front();
            if (got !== exp_ev) $display("FAIL burst_beat %0d: got %h want %h", k, got, exp_ev);
            else passed++;
          end
        end else begin
          exp_err = 1'b1;
        end
      end
      checks++; if (wt_ev.size() !== 0) $display("FAIL burst_extra: got %0d extra pulses want 0", wt_ev.size()); else passed++;
      checks++; if (wrv_n - snap !== 1) $display("FAIL burst_wrv: got %0d want 1", wrv_n - snap); else passed++;
      checks++; if (last_rsp !== (exp_err ? 2'b11 : 2'b00)) $display("FAIL burst_resp: got %b want %b", last_rsp, exp_err ? 2'b11 : 2'b00); else passed++;
      wt_ev.delete(); px_ev.delete();
    end
  endtask

  task automatic test_unmapped();
    int snap;
    bus_read(11'h7FF, 1'b0);
    checks++; if (last_rd !== 32'h0) $display("FAIL unmapped_data: got %h want 0", last_rd); else passed++;
    checks++; if (last_rsp !== 2'b11) $display("FAIL unmapped_resp: got %b want 11", last_rsp); else passed++;
    bus_read(11'h001, 1'b0);
    bus_read(11'h020, 1'b0);
    checks++; if (last_rd !== 32'h0 || last_rsp !== 2'b11) $display("FAIL wo_read: got %h/%b want 0/11", last_rd, last_rsp); else passed++;
    bus_write(11'h00C, $urandom(), 1'b0);
    checks++; if (last_rsp !== 2'b11) $display("FAIL unmapped_write_resp: got %b want 11", last_rsp); else passed++;
    bus_write(11'h710, $urandom(), 1'b0);
    checks++; if (last_rsp !== 2'b11 || wt_ev.size() !== 0) $display("FAIL past_weight: got %b/%0d want 11/0", last_rsp, wt_ev.size()); else passed++;
    px_ev.delete(); wt_ev.delete();
    // Burst read runs as a single beat.
    snap = rdv_n;
    beginbursttransfer = 1'b1; burstcount = 10'd4;
    bus_read(11'h001, 1'b0);
    beginbursttransfer = 1'b0; burstcount = 10'd1;
    checks++; if (rdv_n - snap !== 1 || last_rd !== m_scratch) $display("FAIL burst_read: got %0d pulses data %h want 1 %h", rdv_n - snap, last_rd, m_scratch); else passed++;
  endtask

  task automatic test_reset_mid();
    int snap_w, snap_r;
    snap_w = wrv_n;
    address = 11'h020; writedata = $urandom(); write = 1'b1;
    @(negedge clk);
    checks++; if (waitrequest !== 1'b1) $display("FAIL midreset_busy_wait: got %b want 1", waitrequest); else passed++;
    n_rst = 1'b1; write = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    m_scratch = '0; m_busy = 1'b0; m_done = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (px_ev.size() !== 0 || wrv_n !== snap_w) $display("FAIL midreset_strobes: got %0d enables %0d resp want 0 0", px_ev.size(), wrv_n - snap_w); else passed++;
    checks++; if (waitrequest !== 1'b1) $display("FAIL midreset_idle: got waitrequest %b want 1", waitrequest); else passed++;
    snap_r = rdv_n;
    bus_read(11'h001, 1'b0);
    checks++; if (rdv_n - snap_r !== 1 || last_rd !== m_scratch) $display("FAIL midreset_scratch: got %0d pulses data %h want 1 %h", rdv_n - snap_r, last_rd, m_scratch); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b1; write = 1'b0; read = 1'b0; beginbursttransfer = 1'b0; done_calc = 1'b0;
    burstcount = 10'd1; address = '0; writedata = '0; result_output = '0;
    test_reset();
    test_scratch();
    test_pixel();
    test_ctrl_result();
    test_burst();
    test_unmapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
